// File: rtl/tap_tempo_if.sv
// rtl/tap_tempo_if.sv - tap input and tempo outputs of tap_tempo
interface tap_tempo_if;
  logic       tap;
  logic [7:0] bpm_out;
  logic       bpm_valid;
  logic       active;

  modport master (output tap, input bpm_out, input bpm_valid, input active);
  modport slave  (input tap, output bpm_out, output bpm_valid, output active);
endinterface

// File: rtl/tap_tempo.sv
// rtl/tap_tempo.sv - measures tap spacing and turns the average of the last 4 intervals into BPM
module tap_tempo #(
  parameter int TICK_CYCLES = 50000,
  parameter int LOCKOUT_MS  = 100,
  parameter int TIMEOUT_MS  = 3000,
  parameter int DEFAULT_BPM = 60
) (
  input  logic       clk,
  input  logic       reset,
  tap_tempo_if.slave bus
);
  localparam int              PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [15:0]     LOCKOUT   = 16'(LOCKOUT_MS);
  localparam logic [15:0]     TIMEOUT   = 16'(TIMEOUT_MS);
  localparam logic [4:0]      DIV_LAST  = 5'd17;

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, DONE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q, evt_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [15:0]      ms_q, ms_d;
  logic [3:0][15:0] hist_q, hist_d;
  logic [15:0]      sum_q, sum_d;
  logic [2:0]       n_q, n_d, n_new;
  logic [13:0]      rem_q, rem_d, dvs_q, dvs_d;
  logic [17:0]      quo_q, quo_d, dvd_load;
  logic [4:0]       cnt_q, cnt_d;
  logic [7:0]       bpm_q, bpm_d;
  logic             valid_q, valid_d, active_q;
  logic             tick;
  logic [14:0]      rem_sh;
  logic             ge;
  logic [13:0]      rem_step;
  logic [17:0]      quo_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= bus.tap;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      evt_q   <= sync2_q & ~sync3_q;
    end
  end

  assign tick  = (pre_q == TICK_LAST);
  assign n_new = (n_q == 3'd4) ? 3'd4 : n_q + 3'd1;

  always_comb begin
    case (n_new)
      3'd1:    dvd_load = 18'd60000;
      3'd2:    dvd_load = 18'd120000;
      3'd3:    dvd_load = 18'd180000;
      default: dvd_load = 18'd240000;
    endcase
  end

  // Restoring divide step; a zero divisor yields all-ones quotient, which clamps to 255
  assign rem_sh   = {rem_q, quo_q[17]};
  assign ge       = (rem_sh >= {1'b0, dvs_q});
  assign rem_step = ge ? 14'(rem_sh - {1'b0, dvs_q}) : rem_sh[13:0];
  assign quo_step = {quo_q[16:0], ge};

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
    ms_d    = (tick && ms_q < TIMEOUT) ? ms_q + 16'd1 : ms_q;
    hist_d  = hist_q;
    sum_d   = sum_q;
    n_d     = n_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    bpm_d   = bpm_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt_q) begin
          state_d = MEASURE;
          n_d     = '0;
          sum_d   = '0;
          ms_d    = '0;
          pre_d   = '0;
        end
      end
      MEASURE: begin
        if (ms_q == TIMEOUT) begin
          n_d   = '0;
          sum_d = '0;
          if (evt_q) begin
            ms_d  = '0;
            pre_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (evt_q && ms_q >= LOCKOUT) begin
          // sum_q tracks the window; the oldest entry drops out once it is full
          hist_d  = {hist_q[2:0], ms_q};
          sum_d   = sum_q + ms_q - ((n_q == 3'd4) ? hist_q[3] : 16'd0);
          n_d     = n_new;
          ms_d    = '0;
          pre_d   = '0;
          rem_d   = '0;
          quo_d   = dvd_load;
          dvs_d   = sum_d[13:0];
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DIV_LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
          bpm_d   = (quo_step > 18'd255) ? 8'hFF : quo_step[7:0];
        end
      end
      DONE:    state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      ms_q     <= '0;
      hist_q   <= '0;
      sum_q    <= '0;
      n_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      bpm_q    <= 8'(DEFAULT_BPM);
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      hist_q   <= hist_d;
      sum_q    <= sum_d;
      n_q      <= n_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      bpm_q    <= bpm_d;
      valid_q  <= valid_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign bus.bpm_out   = bpm_q;
  assign bus.bpm_valid = valid_q;
  assign bus.active    = active_q;
endmodule

// File: doc/tap_tempo.md
Name: tap_tempo

Overview:
- Inverse of the tempo-pulse generators: measures the spacing of user button taps and produces an 8-bit BPM value for the tempo generators' bpm input.
- Rolling average over the last 4 tap intervals.
- Sits between the debounced KEY input and the bpm/reset inputs of the metronome pulse blocks.
- bpm_valid is intended to drive the tempo generator's reset so the new tempo loads.

Parameters:
- TICK_CYCLES, 50000, clk cycles per 1 ms tick (50 MHz clock); bench overrides to 10.
- LOCKOUT_MS, 100, taps arriving fewer than this many ms after the previous accepted tap are ignored.
- TIMEOUT_MS, 3000, gap after which the measurement is abandoned (20 BPM floor).
- DEFAULT_BPM, 60, bpm_out value after reset.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- tap, input, 1, raw tap button, asynchronous to clk, already debounced, active-high.
- bpm_out, output, 8, current tempo in beats per minute.
- bpm_valid, output, 1, one-cycle pulse on the cycle bpm_out takes a new value.
- active, output, 1, high while a tap sequence is being measured (state != IDLE).

Behaviour:
- Input path:
  - tap passes through a 2-flop synchroniser, then a registered rising-edge detect, giving tap_evt.
  - tap_evt is high for exactly 1 cycle, in the 3rd clk after tap is first sampled high.
  - Holding tap high produces no further events.
- ms prescaler:
  - Counts 0..TICK_CYCLES-1 and asserts tick on TICK_CYCLES-1.
  - Cleared to 0 on every accepted tap and on entry to MEASURE.
- Interval counter ms_cnt, 16-bit:
  - Increments on tick and saturates at TIMEOUT_MS.
  - Cleared on every accepted tap.
  - On a cycle where tap_evt and tick coincide, the pre-increment value is used.
- History: 4 x 16-bit interval shift register plus count n (0..4, saturating).
- States: IDLE, MEASURE, DIVIDE, DONE.
- IDLE:
  - tap_evt -> MEASURE; n<=0, ms_cnt<=0, prescaler<=0.
- MEASURE:
  - If ms_cnt == TIMEOUT_MS -> IDLE with n<=0; bpm_out holds its last value.
  - If tap_evt occurs on that same cycle, the tap becomes a new first tap instead (stay in MEASURE, n<=0, counters cleared).
  - tap_evt with ms_cnt < LOCKOUT_MS: ignored; counters keep running.
  - Otherwise (accepted tap):
    - Shift ms_cnt into history; n<=min(n+1,4); clear counters.
    - Load dividend = 60000*n_new (18-bit) and divisor = sum of the newest n_new intervals (14-bit).
    - -> DIVIDE.
- DIVIDE:
  - Restoring divider, one quotient bit per cycle, exactly 18 cycles.
  - ms counting continues during DIVIDE.
  - tap_evt during DIVIDE is dropped; it necessarily lies inside the lockout window since LOCKOUT_MS >= 1.
- DONE (1 cycle):
  - bpm_out <= (quotient > 255) ? 255 : quotient[7:0], truncating (no rounding).
  - bpm_valid = 1.
  - -> MEASURE.
- Latency: bpm_valid is high exactly 19 cycles after the tap_evt cycle, i.e. 22 cycles after tap is first sampled high.
- Divide by zero is unreachable because an accepted interval is >= LOCKOUT_MS.
- A divisor of 0 must still yield a clamped 255, with no X.
- Reset (synchronous, including mid-DIVIDE):
  - state<=IDLE, bpm_out<=DEFAULT_BPM, bpm_valid<=0, active<=0.
  - History, n, ms_cnt, prescaler and synchroniser are all cleared.
  - Any in-flight divide is discarded and no bpm_valid is emitted.
- active is registered and follows the state with no lag (state != IDLE).

Test Plan (TICK_CYCLES=10):
- Reset held 3 cycles -> bpm_out=60, bpm_valid=0, active=0. Single tap -> active=1, no bpm_valid.
- Taps 500 ms apart (5000 clk) -> bpm_out=120, with one bpm_valid pulse exactly 22 cycles after the 2nd tap rises.
- 5 taps with intervals 500, 500, 500, 1000 ms -> valid values are 120, 120, 120, then 96 (240000/2500).
- Tap 50 ms after an accepted tap, then another 500 ms after the accepted tap -> no valid pulse for the 50 ms tap; next output is 120.
- 3000 ms with no tap -> active=0 and bpm_out holds its last value. Then taps 1000 ms apart -> bpm_out=60, computed from 1 interval (history restarted).
- Intervals of 100 ms -> quotient 600, bpm_out clamps to 255.
- Assert reset 5 cycles into DIVIDE -> bpm_out=60, no bpm_valid, active=0.
